// File: rtl/adpll_cfg_pkg.sv
// Shared constants and types for the ADPLL configuration bank.
package adpll_cfg_pkg;

   // Parameter word indices as seen by the loop filter and NCO
   localparam int IDX_NDIV       = 0;
   localparam int IDX_ALPHA      = 1;
   localparam int IDX_BETA       = 2;
   localparam int IDX_NCO_OFFSET = 3;
   localparam int IDX_NCO_THRESH = 4;
   localparam int IDX_KNCO       = 5;

   localparam int DEF_DW     = 5;
   localparam int DEF_NPARAM = 6;
   localparam int DEF_SELW   = 3;

   // Depth of the pin strobe synchroniser
   localparam int SYNC_STAGES = 3;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ARMED = 1'b1
   } cfg_state_e;

endpackage

// File: rtl/adpll_cfg_bank_if.sv
// Programming / readback bus of the configuration bank.
interface adpll_cfg_bank_if
   import adpll_cfg_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int NPARAM = DEF_NPARAM,
   parameter int SELW   = DEF_SELW
);
   logic                 prog;
   logic [SELW-1:0]      param_sel;
   logic [DW-1:0]        pgm_value;
   logic                 clr;
   logic                 commit;
   logic                 upd;
   logic [SELW-1:0]      rd_sel;
   logic [DW-1:0]        rd_data;
   logic [NPARAM*DW-1:0] cfg_active;
   logic                 cfg_update;
   logic                 pending;
   logic                 wr_err;

   modport master (
      output prog, param_sel, pgm_value, clr, commit, upd, rd_sel,
      input  rd_data, cfg_active, cfg_update, pending, wr_err
   );

   modport slave (
      input  prog, param_sel, pgm_value, clr, commit, upd, rd_sel,
      output rd_data, cfg_active, cfg_update, pending, wr_err
   );
endinterface

// File: rtl/adpll_pulse_sync.sv
// Synchroniser for an async pin strobe with rising-edge detect on the
// last two stages.
module adpll_pulse_sync
   import adpll_cfg_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic rise
);
   logic [STAGES:1] sync_pipe;

   // shift the pin level through the synchroniser chain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) sync_pipe <= '0;
      else      sync_pipe <= {sync_pipe[STAGES-1:1], async_in};
   end

   assign rise = sync_pipe[STAGES-1] & ~sync_pipe[STAGES];
endmodule

// File: rtl/adpll_cfg_bank.sv
// Shadow/active parameter bank: pin writes land in shadow, and the whole
// bank is copied to active only on a loop-update strobe after a commit.
module adpll_cfg_bank
   import adpll_cfg_pkg::*;
#(
   parameter int DW     = DEF_DW,
   parameter int NPARAM = DEF_NPARAM,
   parameter int SELW   = DEF_SELW
) (
   input logic              clk,
   input logic              rst,
   adpll_cfg_bank_if.slave  bus
);
   logic                 wr;
   logic [NPARAM-1:0]    wr_hit;
   logic                 wr_oor;
   logic                 xfer;
   cfg_state_e           state, state_nxt;
   logic [DW-1:0]        shadow [NPARAM];
   logic [DW-1:0]        active [NPARAM];
   logic                 pending_q, wr_err_q, cfg_update_q;
   logic [DW-1:0]        rd_data_c;
   logic [NPARAM*DW-1:0] active_flat;

   adpll_pulse_sync u_prog_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (bus.prog),
      .rise     (wr)
   );

   // one-hot decode of the write target; no hit means the index is out of range
   for (genvar i = 0; i < NPARAM; i++) begin : g_hit
      assign wr_hit[i] = wr && (bus.param_sel == SELW'(i));
   end
   assign wr_oor = wr && ~|wr_hit;

   // commit FSM: transfer on upd once a commit has been seen; clr aborts
   always_comb begin
      state_nxt = state;
      xfer      = 1'b0;
      case (state)
         ST_IDLE:
            if (bus.commit) begin
               if (bus.upd) xfer      = 1'b1;
               else         state_nxt = ST_ARMED;
            end
         ST_ARMED:
            if (bus.upd) begin
               xfer      = 1'b1;
               state_nxt = ST_IDLE;
            end
         default: state_nxt = ST_IDLE;
      endcase
      if (bus.clr) begin
         state_nxt = ST_IDLE;
         xfer      = 1'b0;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // banks: active samples the pre-write shadow when both happen on one edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NPARAM; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else if (bus.clr) begin
         for (int i = 0; i < NPARAM; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NPARAM; i++) begin
            if (xfer)      active[i] <= shadow[i];
            if (wr_hit[i]) shadow[i] <= bus.pgm_value;
         end
      end
   end

   // status flags; a fresh in-range write keeps pending set through a transfer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_q    <= 1'b0;
         wr_err_q     <= 1'b0;
         cfg_update_q <= 1'b0;
      end else if (bus.clr) begin
         pending_q    <= 1'b0;
         wr_err_q     <= 1'b0;
         cfg_update_q <= 1'b0;
      end else begin
         cfg_update_q <= xfer;
         if (|wr_hit)   pending_q <= 1'b1;
         else if (xfer) pending_q <= 1'b0;
         if (wr_oor)    wr_err_q  <= 1'b1;
      end
   end

   // shadow readback, zero for unmapped indices
   always_comb begin
      rd_data_c = '0;
      for (int i = 0; i < NPARAM; i++)
         if (bus.rd_sel == SELW'(i)) rd_data_c = shadow[i];
   end

   // flatten the active bank, index i at [i*DW +: DW]
   always_comb begin
      active_flat = '0;
      for (int i = 0; i < NPARAM; i++)
         active_flat[i*DW +: DW] = active[i];
   end

   assign bus.rd_data    = rd_data_c;
   assign bus.cfg_active = active_flat;
   assign bus.cfg_update = cfg_update_q;
   assign bus.pending    = pending_q;
   assign bus.wr_err     = wr_err_q;
endmodule

// File: tb/tb_adpll_cfg_bank.sv
// Bench for adpll_cfg_bank: directed stimulus, scoreboard queues checked
// by monitors on every cfg_update pulse, plus direct state checks.
module tb_adpll_cfg_bank;
   typedef struct packed {
      logic [29:0] act;
      logic        pend;
   } exp5_t;

   typedef struct packed {
      logic [63:0] act;
      logic        pend;
   } exp8_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;
   exp5_t q5[$];
   exp8_t q8[$];

   adpll_cfg_bank_if #(.DW(5), .NPARAM(6), .SELW(3)) b5 ();
   adpll_cfg_bank_if #(.DW(8), .NPARAM(8), .SELW(3)) b8 ();

   adpll_cfg_bank #(.DW(5), .NPARAM(6), .SELW(3)) u5 (
      .clk (clk), .rst (rst), .bus (b5.slave));
   adpll_cfg_bank #(.DW(8), .NPARAM(8), .SELW(3)) u8 (
      .clk (clk), .rst (rst), .bus (b8.slave));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pgm5(input logic [2:0] sel, input logic [4:0] val);
      b5.param_sel = sel;
      b5.pgm_value = val;
      b5.prog      = 1'b1;
      cyc(3);
      b5.prog      = 1'b0;
      cyc(3);
   endtask

   // monitor for the default instance
   always @(negedge clk) begin
      if (rst && b5.cfg_update) begin
         if (q5.size() == 0) begin
            total++;
            bad++;
            $display("FAIL cfg_update5: got unexpected pulse, expected none");
         end else begin
            exp5_t e;
            e = q5.pop_front();
            chk("xfer_active5", 64'(b5.cfg_active), 64'(e.act));
            chk("xfer_pending5", 64'(b5.pending), 64'(e.pend));
         end
      end
   end

   // monitor for the wide instance
   always @(negedge clk) begin
      if (rst && b8.cfg_update) begin
         if (q8.size() == 0) begin
            total++;
            bad++;
            $display("FAIL cfg_update8: got unexpected pulse, expected none");
         end else begin
            exp8_t e;
            e = q8.pop_front();
            chk("xfer_active8", 64'(b8.cfg_active), e.act);
            chk("xfer_pending8", 64'(b8.pending), 64'(e.pend));
         end
      end
   end

   initial begin
      logic ok;
      {b5.prog, b5.param_sel, b5.pgm_value, b5.clr, b5.commit, b5.upd, b5.rd_sel} = '0;
      {b8.prog, b8.param_sel, b8.pgm_value, b8.clr, b8.commit, b8.upd, b8.rd_sel} = '0;
      cyc(3);
      chk("rst_rd_data", 64'(b5.rd_data), 64'd0);
      chk("rst_active", 64'(b5.cfg_active), 64'd0);
      chk("rst_update", 64'(b5.cfg_update), 64'd0);
      chk("rst_pending", 64'(b5.pending), 64'd0);
      chk("rst_wr_err", 64'(b5.wr_err), 64'd0);
      rst = 1'b1;
      cyc(2);

      // reset taken while ARMED discards the request
      pgm5(3'd0, 5'd3);
      chk("pre_rst_pending", 64'(b5.pending), 64'd1);
      b5.commit = 1'b1;
      cyc(1);
      b5.commit = 1'b0;
      #4 rst = 1'b0;
      #1;
      chk("midrst_rd_data", 64'(b5.rd_data), 64'd0);
      chk("midrst_pending", 64'(b5.pending), 64'd0);
      chk("midrst_active", 64'(b5.cfg_active), 64'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      cyc(2);
      b5.upd = 1'b1;
      cyc(1);
      b5.upd = 1'b0;
      cyc(2);
      chk("post_rst_upd_active", 64'(b5.cfg_active), 64'd0);

      // first write after reset: visible three edges after the rise
      b5.rd_sel    = 3'd1;
      b5.param_sel = 3'd1;
      b5.pgm_value = 5'h0B;
      b5.prog      = 1'b1;
      cyc(2);
      chk("wr_not_yet", 64'(b5.rd_data), 64'd0);
      cyc(1);
      chk("wr_e2_rd", 64'(b5.rd_data), 64'h0B);
      chk("wr_e2_pending", 64'(b5.pending), 64'd1);
      chk("wr_e2_active", 64'(b5.cfg_active), 64'd0);
      cyc(1);
      b5.prog = 1'b0;
      cyc(3);

      // full bank, commit waits for upd
      for (int i = 0; i < 6; i++) pgm5(3'(i), 5'(i + 1));
      b5.commit = 1'b1;
      cyc(1);
      b5.commit = 1'b0;
      repeat (4) begin
         chk("held_until_upd", 64'(b5.cfg_active), 64'd0);
         cyc(1);
      end
      q5.push_back('{act: {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}, pend: 1'b0});
      b5.upd = 1'b1;
      cyc(1);
      b5.upd = 1'b0;
      chk("commit_pending", 64'(b5.pending), 64'd0);
      cyc(3);

      // commit and upd in the same cycle
      pgm5(3'd0, 5'd9);
      q5.push_back('{act: {5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd9}, pend: 1'b0});
      b5.commit = 1'b1;
      b5.upd    = 1'b1;
      cyc(1);
      b5.commit = 1'b0;
      b5.upd    = 1'b0;
      cyc(2);

      // write and transfer on the same edge
      pgm5(3'd2, 5'h0C);
      b5.commit = 1'b1;
      cyc(1);
      b5.commit = 1'b0;
      q5.push_back('{act: {5'd6, 5'd5, 5'd4, 5'h0C, 5'd2, 5'd9}, pend: 1'b1});
      b5.rd_sel    = 3'd1;
      b5.param_sel = 3'd1;
      b5.pgm_value = 5'h1F;
      b5.prog      = 1'b1;
      cyc(2);
      b5.upd = 1'b1;
      cyc(1);
      b5.upd = 1'b0;
      chk("coinc_shadow", 64'(b5.rd_data), 64'h1F);
      cyc(1);
      b5.prog = 1'b0;
      cyc(3);
      chk("coinc_pending", 64'(b5.pending), 64'd1);

      // out-of-range write
      q5.push_back('{act: {5'd6, 5'd5, 5'd4, 5'h0C, 5'h1F, 5'd9}, pend: 1'b0});
      b5.commit = 1'b1;
      b5.upd    = 1'b1;
      cyc(1);
      b5.commit = 1'b0;
      b5.upd    = 1'b0;
      cyc(2);
      pgm5(3'd7, 5'h15);
      chk("oor_wr_err", 64'(b5.wr_err), 64'd1);
      chk("oor_pending", 64'(b5.pending), 64'd0);
      chk("oor_active", 64'(b5.cfg_active), 64'({5'd6, 5'd5, 5'd4, 5'h0C, 5'h1F, 5'd9}));
      b5.rd_sel = 3'd7;
      #1 chk("oor_rd", 64'(b5.rd_data), 64'd0);
      b5.rd_sel = 3'd5;
      #1 chk("oor_rd5", 64'(b5.rd_data), 64'd6);
      cyc(1);
      pgm5(3'd4, 5'h0E);
      chk("wr_err_sticky", 64'(b5.wr_err), 64'd1);
      chk("pending_after_oor", 64'(b5.pending), 64'd1);
      b5.clr = 1'b1;
      cyc(1);
      b5.clr = 1'b0;
      b5.rd_sel = 3'd4;
      #1;
      chk("clr_wr_err", 64'(b5.wr_err), 64'd0);
      chk("clr_pending", 64'(b5.pending), 64'd0);
      chk("clr_active", 64'(b5.cfg_active), 64'd0);
      chk("clr_shadow", 64'(b5.rd_data), 64'd0);
      cyc(1);

      // clr beats an armed upd, and leaves the FSM idle
      pgm5(3'd3, 5'd7);
      b5.commit = 1'b1;
      cyc(1);
      b5.commit = 1'b0;
      cyc(1);
      b5.clr = 1'b1;
      b5.upd = 1'b1;
      cyc(1);
      b5.clr = 1'b0;
      b5.upd = 1'b0;
      cyc(2);
      chk("clrprio_active", 64'(b5.cfg_active), 64'd0);
      chk("clrprio_pending", 64'(b5.pending), 64'd0);
      b5.upd = 1'b1;
      cyc(1);
      b5.upd = 1'b0;
      cyc(2);
      chk("clrprio_idle", 64'(b5.cfg_active), 64'd0);

      // sub-cycle glitch between edges is never sampled
      b5.rd_sel    = 3'd2;
      b5.param_sel = 3'd2;
      b5.pgm_value = 5'h11;
      b5.prog      = 1'b1;
      #2 b5.prog   = 1'b0;
      cyc(4);
      chk("glitch_short_pending", 64'(b5.pending), 64'd0);
      chk("glitch_short_rd", 64'(b5.rd_data), 64'd0);
      // single-cycle pulse: at most one write
      b5.prog = 1'b1;
      cyc(1);
      b5.prog = 1'b0;
      cyc(4);
      ok = (b5.rd_data == 5'h00) || (b5.rd_data == 5'h11);
      chk("glitch_1cyc_value", 64'(ok), 64'd1);

      // wide instance
      b8.rd_sel    = 3'd7;
      b8.param_sel = 3'd7;
      b8.pgm_value = 8'hA5;
      b8.prog      = 1'b1;
      cyc(3);
      b8.prog      = 1'b0;
      cyc(3);
      chk("w8_rd", 64'(b8.rd_data), 64'hA5);
      q8.push_back('{act: {8'hA5, 56'h0}, pend: 1'b0});
      b8.commit = 1'b1;
      b8.upd    = 1'b1;
      cyc(1);
      b8.commit = 1'b0;
      b8.upd    = 1'b0;
      cyc(2);
      chk("w8_top_byte", 64'(b8.cfg_active[63:56]), 64'hA5);

      cyc(2);
      chk("q5_drained", 64'(q5.size()), 64'd0);
      chk("q8_drained", 64'(q8.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
